// File: rtl/a_bus_controller.sv
// a_bus_controller
//   Sequential half of the bus arbiter. It takes the priority selector's picks
//   (request / sel_master / sel_slave), owns the bus FSM, the current owner
//   registers and the split-threshold counter, and feeds that state back to
//   the selector. Every output comes straight from a flop.
//
// Ports
//   clk, rst       clock (rising edge) and asynchronous active-high reset
//   request        selector: at least one master is requesting
//   sel_master     selector's chosen master index
//   sel_slave      selector's chosen slave id (0 = none)
//   done           per-master release/ack; only bit [cur_master] is used
//   state          to selector: 0 = idle, 1 = bus owned
//   cur_master     to selector: current owner
//   cur_slave      to selector: current target slave
//   thresh         to selector: BUSY has lasted THRESH_CYCLES cycles
//   grant          one-hot bus grant
//   slave_sel      slave mux select (0 = none)
//   preempt        one-cycle release request to the current owner
module a_bus_controller #(
  parameter int NO_MASTERS    = 2,
  parameter int NO_SLAVES     = 3,
  parameter int S_ID_WIDTH    = $clog2(NO_SLAVES + 1),
  parameter int M_ID_WIDTH    = $clog2(NO_MASTERS),
  parameter int THRESH_CYCLES = 8,
  parameter int CNT_WIDTH     = $clog2(THRESH_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  request,
  input  logic [M_ID_WIDTH-1:0] sel_master,
  input  logic [S_ID_WIDTH-1:0] sel_slave,
  input  logic [NO_MASTERS-1:0] done,
  output logic                  state,
  output logic [M_ID_WIDTH-1:0] cur_master,
  output logic [S_ID_WIDTH-1:0] cur_slave,
  output logic                  thresh,
  output logic [NO_MASTERS-1:0] grant,
  output logic [S_ID_WIDTH-1:0] slave_sel,
  output logic [NO_MASTERS-1:0] preempt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_BUSY     = 2'd2,
    ST_HANDOVER = 2'd3
  } fsm_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(THRESH_CYCLES);

  fsm_t                  fsm_q, fsm_d;
  logic [M_ID_WIDTH-1:0] cur_master_q, cur_master_d;
  logic [S_ID_WIDTH-1:0] cur_slave_q, cur_slave_d;
  logic [M_ID_WIDTH-1:0] pend_master_q, pend_master_d;
  logic [S_ID_WIDTH-1:0] pend_slave_q, pend_slave_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  state_q, state_d;
  logic                  thresh_q, thresh_d;
  logic [NO_MASTERS-1:0] grant_q, grant_d;
  logic [S_ID_WIDTH-1:0] slave_sel_q, slave_sel_d;
  logic [NO_MASTERS-1:0] preempt_q, preempt_d;

  always_comb begin
    fsm_d         = fsm_q;
    cur_master_d  = cur_master_q;
    cur_slave_d   = cur_slave_q;
    pend_master_d = pend_master_q;
    pend_slave_d  = pend_slave_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    slave_sel_d   = slave_sel_q;
    preempt_d     = '0;
    thresh_d      = 1'b0;

    unique case (fsm_q)
      ST_IDLE: begin
        grant_d     = '0;
        slave_sel_d = '0;
        cnt_d       = '0;
        if (request) begin
          fsm_d                = ST_GRANT;
          cur_master_d         = sel_master;
          cur_slave_d          = sel_slave;
          grant_d[sel_master]  = 1'b1;
          slave_sel_d          = sel_slave;
        end
      end

      ST_GRANT: begin
        // Grant is (re)asserted here so that an owner arriving from HANDOVER
        // sees it one cycle after the previous owner's grant dropped.
        fsm_d                 = ST_BUSY;
        cnt_d                 = '0;
        grant_d               = '0;
        grant_d[cur_master_q] = 1'b1;
        slave_sel_d           = cur_slave_q;
      end

      ST_BUSY: begin
        if (done[cur_master_q]) begin
          // Release wins over any simultaneous preempt candidate.
          fsm_d       = ST_IDLE;
          grant_d     = '0;
          slave_sel_d = '0;
          cnt_d       = '0;
        end else if (request && (sel_master != cur_master_q)) begin
          fsm_d                   = ST_HANDOVER;
          pend_master_d           = sel_master;
          pend_slave_d            = sel_slave;
          preempt_d[cur_master_q] = 1'b1;
        end else begin
          if (cnt_q != CNT_LIMIT) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
          thresh_d = (cnt_d == CNT_LIMIT);
        end
      end

      ST_HANDOVER: begin
        // Outgoing master keeps its grant until it acknowledges; no timeout.
        if (done[cur_master_q]) begin
          fsm_d        = ST_GRANT;
          cur_master_d = pend_master_q;
          cur_slave_d  = pend_slave_q;
          grant_d      = '0;
          slave_sel_d  = '0;
          cnt_d        = '0;
        end
      end

      default: begin
        fsm_d       = ST_IDLE;
        grant_d     = '0;
        slave_sel_d = '0;
        cnt_d       = '0;
      end
    endcase

    state_d = (fsm_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q         <= ST_IDLE;
      cur_master_q  <= '0;
      cur_slave_q   <= '0;
      pend_master_q <= '0;
      pend_slave_q  <= '0;
      cnt_q         <= '0;
      state_q       <= 1'b0;
      thresh_q      <= 1'b0;
      grant_q       <= '0;
      slave_sel_q   <= '0;
      preempt_q     <= '0;
    end else begin
      fsm_q         <= fsm_d;
      cur_master_q  <= cur_master_d;
      cur_slave_q   <= cur_slave_d;
      pend_master_q <= pend_master_d;
      pend_slave_q  <= pend_slave_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      thresh_q      <= thresh_d;
      grant_q       <= grant_d;
      slave_sel_q   <= slave_sel_d;
      preempt_q     <= preempt_d;
    end
  end

  assign state      = state_q;
  assign cur_master = cur_master_q;
  assign cur_slave  = cur_slave_q;
  assign thresh     = thresh_q;
  assign grant      = grant_q;
  assign slave_sel  = slave_sel_q;
  assign preempt    = preempt_q;

endmodule

// File: tb/tb_a_bus_controller.sv
// tb_a_bus_controller
//   Directed bench for a_bus_controller with default parameters
//   (2 masters, 3 slaves, threshold 8). Inputs change 1 time unit after a
//   rising edge; outputs are checked at the same point.
module tb_a_bus_controller;

  logic       clk;
  logic       rst;
  logic       request;
  logic [0:0] sel_master;
  logic [1:0] sel_slave;
  logic [1:0] done;
  logic       state;
  logic [0:0] cur_master;
  logic [1:0] cur_slave;
  logic       thresh;
  logic [1:0] grant;
  logic [1:0] slave_sel;
  logic [1:0] preempt;

  int passed = 0;
  int total  = 0;

  a_bus_controller dut (
    .clk        (clk),
    .rst        (rst),
    .request    (request),
    .sel_master (sel_master),
    .sel_slave  (sel_slave),
    .done       (done),
    .state      (state),
    .cur_master (cur_master),
    .cur_slave  (cur_slave),
    .thresh     (thresh),
    .grant      (grant),
    .slave_sel  (slave_sel),
    .preempt    (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Acquire the bus for master m / slave s and advance into BUSY.
  task automatic acquire(input logic [0:0] m, input logic [1:0] s);
    request = 1'b1; sel_master = m; sel_slave = s; done = 2'b00;
    step();  // GRANT
    request = 1'b0;
    step();  // BUSY
  endtask

  task automatic test_reset();
    rst = 1'b1; request = 1'b0; sel_master = '0; sel_slave = '0; done = '0;
    step();
    total++; if (state !== 1'b0) $display("FAIL reset_state: got %b expected 0", state); else passed++;
    total++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b expected 00", grant); else passed++;
    total++; if (slave_sel !== 2'd0) $display("FAIL reset_slave_sel: got %0d expected 0", slave_sel); else passed++;
    total++; if (preempt !== 2'b00) $display("FAIL reset_preempt: got %b expected 00", preempt); else passed++;
    total++; if (thresh !== 1'b0) $display("FAIL reset_thresh: got %b expected 0", thresh); else passed++;
    total++; if (cur_master !== 1'b0 || cur_slave !== 2'd0) $display("FAIL reset_cur: got m%0d s%0d expected m0 s0", cur_master, cur_slave); else passed++;
    rst = 1'b0;
    step();
    total++; if (state !== 1'b0) $display("FAIL idle_no_request: got %b expected 0", state); else passed++;
    $display("[tb] test_reset complete");
  endtask

  task automatic test_single_request();
    request = 1'b1; sel_master = 1'b1; sel_slave = 2'd2;
    step();
    total++; if (grant !== 2'b10) $display("FAIL single_grant: got %b expected 10", grant); else passed++;
    total++; if (slave_sel !== 2'd2) $display("FAIL single_slave_sel: got %0d expected 2", slave_sel); else passed++;
    total++; if (state !== 1'b1) $display("FAIL single_state: got %b expected 1", state); else passed++;
    total++; if (cur_master !== 1'b1 || cur_slave !== 2'd2) $display("FAIL single_cur: got m%0d s%0d expected m1 s2", cur_master, cur_slave); else passed++;
    request = 1'b0;
    done = 2'b10;  // done while in GRANT must be ignored
    step();
    total++; if (grant !== 2'b10 || state !== 1'b1) $display("FAIL grant_done_ignored: got grant %b state %b expected 10/1", grant, state); else passed++;
    done = 2'b01;  // non-owner done ignored in BUSY
    step();
    total++; if (grant !== 2'b10 || state !== 1'b1) $display("FAIL nonowner_done: got grant %b state %b expected 10/1", grant, state); else passed++;
    $display("[tb] test_single_request complete");
  endtask

  task automatic test_release();
    done = 2'b10;
    step();
    total++; if (grant !== 2'b00) $display("FAIL release_grant: got %b expected 00", grant); else passed++;
    total++; if (slave_sel !== 2'd0) $display("FAIL release_slave_sel: got %0d expected 0", slave_sel); else passed++;
    total++; if (state !== 1'b0) $display("FAIL release_state: got %b expected 0", state); else passed++;
    done = 2'b00;
    $display("[tb] test_release complete");
  endtask

  task automatic test_preempt();
    acquire(1'b1, 2'd2);
    request = 1'b1; sel_master = 1'b0; sel_slave = 2'd3;
    step();
    total++; if (preempt !== 2'b10) $display("FAIL preempt_pulse: got %b expected 10", preempt); else passed++;
    total++; if (grant !== 2'b10 || slave_sel !== 2'd2) $display("FAIL handover_hold: got grant %b sel %0d expected 10/2", grant, slave_sel); else passed++;
    sel_master = 1'b1; sel_slave = 2'd1;  // selector ignored in HANDOVER
    step();
    total++; if (preempt !== 2'b00) $display("FAIL preempt_one_cycle: got %b expected 00", preempt); else passed++;
    total++; if (grant !== 2'b10) $display("FAIL handover_wait: got %b expected 10", grant); else passed++;
    request = 1'b0;
    done = 2'b10;
    step();
    total++; if (grant !== 2'b00 || slave_sel !== 2'd0) $display("FAIL handover_gap: got grant %b sel %0d expected 00/0", grant, slave_sel); else passed++;
    total++; if (state !== 1'b1) $display("FAIL handover_gap_state: got %b expected 1", state); else passed++;
    total++; if (cur_master !== 1'b0 || cur_slave !== 2'd3) $display("FAIL handover_cur: got m%0d s%0d expected m0 s3", cur_master, cur_slave); else passed++;
    done = 2'b00;
    step();
    total++; if (grant !== 2'b01 || slave_sel !== 2'd3) $display("FAIL new_owner: got grant %b sel %0d expected 01/3", grant, slave_sel); else passed++;
    done = 2'b01;
    step();
    total++; if (state !== 1'b0 || grant !== 2'b00) $display("FAIL preempt_release: got state %b grant %b expected 0/00", state, grant); else passed++;
    done = 2'b00;
    $display("[tb] test_preempt complete");
  endtask

  task automatic test_threshold();
    acquire(1'b0, 2'd1);  // now one edge into BUSY, cnt = 0
    for (int i = 1; i < 8; i++) begin
      step();
      total++; if (thresh !== 1'b0) $display("FAIL thresh_early_%0d: got %b expected 0", i, thresh); else passed++;
    end
    step();
    total++; if (thresh !== 1'b1) $display("FAIL thresh_rise: got %b expected 1", thresh); else passed++;
    step();
    total++; if (thresh !== 1'b1) $display("FAIL thresh_hold: got %b expected 1", thresh); else passed++;
    request = 1'b1; sel_master = 1'b1; sel_slave = 2'd2;
    step();
    total++; if (thresh !== 1'b0 || preempt !== 2'b01) $display("FAIL thresh_handover: got thresh %b preempt %b expected 0/01", thresh, preempt); else passed++;
    request = 1'b0; done = 2'b01;
    step();
    done = 2'b00;
    total++; if (thresh !== 1'b0) $display("FAIL thresh_grant_clear: got %b expected 0", thresh); else passed++;
    step();
    total++; if (thresh !== 1'b0 || grant !== 2'b10) $display("FAIL thresh_fresh: got thresh %b grant %b expected 0/10", thresh, grant); else passed++;
    done = 2'b10;
    step();
    done = 2'b00;
    total++; if (state !== 1'b0) $display("FAIL thresh_release: got %b expected 0", state); else passed++;
    $display("[tb] test_threshold complete");
  endtask

  task automatic test_simultaneous();
    acquire(1'b1, 2'd2);
    done = 2'b10; request = 1'b1; sel_master = 1'b0; sel_slave = 2'd3;
    step();
    total++; if (state !== 1'b0 || preempt !== 2'b00 || grant !== 2'b00) $display("FAIL simult_idle: got state %b preempt %b grant %b expected 0/00/00", state, preempt, grant); else passed++;
    done = 2'b00;
    step();
    total++; if (grant !== 2'b01 || slave_sel !== 2'd3) $display("FAIL simult_regrant: got grant %b sel %0d expected 01/3", grant, slave_sel); else passed++;
    request = 1'b0;
    step();
    done = 2'b01;
    step();
    done = 2'b00;
    total++; if (state !== 1'b0) $display("FAIL simult_release: got %b expected 0", state); else passed++;
    $display("[tb] test_simultaneous complete");
  endtask

  task automatic test_async_reset();
    acquire(1'b1, 2'd2);
    request = 1'b1; sel_master = 1'b0; sel_slave = 2'd3;
    step();  // HANDOVER
    request = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++; if (grant !== 2'b00 || slave_sel !== 2'd0 || state !== 1'b0 || preempt !== 2'b00) $display("FAIL async_reset: got grant %b sel %0d state %b preempt %b expected all 0", grant, slave_sel, state, preempt); else passed++;
    #1;
    rst = 1'b0;
    done = 2'b10;  // would have finished the handover
    step();
    total++; if (state !== 1'b0 || grant !== 2'b00) $display("FAIL reset_discard: got state %b grant %b expected 0/00", state, grant); else passed++;
    done = 2'b00; request = 1'b1; sel_master = 1'b1; sel_slave = 2'd1;
    step();
    total++; if (grant !== 2'b10 || cur_slave !== 2'd1) $display("FAIL post_reset_grant: got grant %b slave %0d expected 10/1", grant, cur_slave); else passed++;
    request = 1'b0;
    $display("[tb] test_async_reset complete");
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_release();
    test_preempt();
    test_threshold();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
